// File: rtl/decoder_pkg.sv
// rtl/decoder_pkg.sv - mode encodings shared by the decoder_scan slice
package decoder_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_HOLD   = 2'b00;
  localparam mode_t MODE_DIRECT = 2'b01;
  localparam mode_t MODE_SCAN   = 2'b10;
  localparam mode_t MODE_RSVD   = 2'b11;

endpackage

// File: rtl/onehot_dec.sv
// rtl/onehot_dec.sv - combinational binary-to-one-hot decoder with range flag
module onehot_dec #(
  parameter int SEL_W = 2,
  parameter int N_OUT = 2 ** SEL_W
) (
  input  logic [SEL_W-1:0] i_idx,
  output logic [N_OUT-1:0] o_onehot,
  output logic             o_in_range
);

  always_comb begin
    o_onehot = '0;
    for (int i = 0; i < N_OUT; i++) begin
      o_onehot[i] = (i_idx == SEL_W'(i));
    end
  end

  // An index past N_OUT-1 matches no output, so the vector is all-zero.
  assign o_in_range = |o_onehot;

endmodule

// File: rtl/decoder_scan.sv
// rtl/decoder_scan.sv - registered one-hot decoder with DIRECT and auto-SCAN modes
module decoder_scan
  import decoder_pkg::*;
#(
  parameter int SEL_W   = 2,
  parameter int N_OUT   = 2 ** SEL_W,
  parameter int DWELL_W = 8
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_en,
  input  logic [1:0]         i_mode,
  input  logic [SEL_W-1:0]   i_sel,
  input  logic [DWELL_W-1:0] i_dwell,
  input  logic               i_err_clr,
  output logic [N_OUT-1:0]   o_d_out,
  output logic               o_valid,
  output logic               o_err,
  output logic               o_scan_wrap
);

  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(N_OUT - 1);

  mode_t              r_prev_mode;
  logic [SEL_W-1:0]   r_index;
  logic [DWELL_W-1:0] r_dwell_cnt;
  logic [SEL_W-1:0]   w_idx_next;
  logic [SEL_W-1:0]   w_dec_idx;
  logic [N_OUT-1:0]   w_onehot;
  logic               w_in_range;

  // Scan entry restarts at 0; steady state walks forward and wraps.
  always_comb begin
    w_idx_next = '0;
    if (r_prev_mode == MODE_SCAN && r_index != LAST_IDX) begin
      w_idx_next = r_index + 1'b1;
    end
  end

  assign w_dec_idx = (mode_t'(i_mode) == MODE_SCAN) ? w_idx_next : i_sel;

  onehot_dec #(
    .SEL_W (SEL_W),
    .N_OUT (N_OUT)
  ) u_dec (
    .i_idx      (w_dec_idx),
    .o_onehot   (w_onehot),
    .o_in_range (w_in_range)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_d_out     <= '0;
      o_valid     <= 1'b0;
      o_err       <= 1'b0;
      o_scan_wrap <= 1'b0;
      r_index     <= '0;
      r_dwell_cnt <= '0;
      r_prev_mode <= MODE_HOLD;
    end else begin
      o_scan_wrap <= 1'b0;
      // Clear first so an error set later in this block wins.
      if (i_err_clr) begin
        o_err <= 1'b0;
      end
      if (i_en) begin
        r_prev_mode <= mode_t'(i_mode);
        case (mode_t'(i_mode))
          MODE_HOLD: begin
          end
          MODE_DIRECT: begin
            if (w_in_range) begin
              o_d_out <= w_onehot;
              o_valid <= 1'b1;
              r_index <= i_sel;
            end else begin
              o_err <= 1'b1;
            end
          end
          MODE_SCAN: begin
            if (r_prev_mode != MODE_SCAN) begin
              o_d_out     <= w_onehot;
              o_valid     <= 1'b1;
              r_index     <= '0;
              r_dwell_cnt <= '0;
            end else if (r_dwell_cnt >= i_dwell) begin
              o_d_out     <= w_onehot;
              r_index     <= w_idx_next;
              r_dwell_cnt <= '0;
              o_scan_wrap <= (r_index == LAST_IDX);
            end else begin
              r_dwell_cnt <= r_dwell_cnt + 1'b1;
            end
          end
          default: begin
            o_err <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_decoder_scan.sv
// tb/tb_decoder_scan.sv - directed self-checking bench for decoder_scan
module tb_decoder_scan;

  localparam int SEL_W   = 3;
  localparam int N_OUT   = 6;
  localparam int DWELL_W = 4;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               en;
  logic [1:0]         mode;
  logic [SEL_W-1:0]   sel;
  logic [DWELL_W-1:0] dwell;
  logic               err_clr;
  logic [N_OUT-1:0]   d_out;
  logic               valid;
  logic               err;
  logic               scan_wrap;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  decoder_scan #(
    .SEL_W   (SEL_W),
    .N_OUT   (N_OUT),
    .DWELL_W (DWELL_W)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_en        (en),
    .i_mode      (mode),
    .i_sel       (sel),
    .i_dwell     (dwell),
    .i_err_clr   (err_clr),
    .o_d_out     (d_out),
    .o_valid     (valid),
    .o_err       (err),
    .o_scan_wrap (scan_wrap)
  );

  // Inputs change and outputs are sampled on the falling edge.
  task automatic cycle();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; mode = 2'b00; sel = '0; dwell = '0; err_clr = 1'b0;
    cycle();
    n_vec++; if (d_out !== 6'b000000) begin n_bad++; $display("FAIL reset_d_out: got %b expected 000000", d_out); end
    n_vec++; if (valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b expected 0", valid); end
    n_vec++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b expected 0", err); end
    n_vec++; if (scan_wrap !== 1'b0) begin n_bad++; $display("FAIL reset_wrap: got %b expected 0", scan_wrap); end
    rst_n = 1'b1;
    cycle();
    n_vec++; if (valid !== 1'b0) begin n_bad++; $display("FAIL hold_after_reset_valid: got %b expected 0", valid); end
  endtask

  task automatic test_direct();
    mode = 2'b01; sel = 3'd5;
    cycle();
    n_vec++; if (d_out !== 6'b100000) begin n_bad++; $display("FAIL direct_sel5: got %b expected 100000", d_out); end
    n_vec++; if (valid !== 1'b1) begin n_bad++; $display("FAIL direct_valid: got %b expected 1", valid); end
    n_vec++; if (err !== 1'b0) begin n_bad++; $display("FAIL direct_err: got %b expected 0", err); end
    sel = 3'd0;
    cycle();
    n_vec++; if (d_out !== 6'b000001) begin n_bad++; $display("FAIL direct_sel0: got %b expected 000001", d_out); end
    sel = 3'd3; mode = 2'b00;
    cycle();
    n_vec++; if (d_out !== 6'b000001) begin n_bad++; $display("FAIL hold_keeps_d_out: got %b expected 000001", d_out); end
  endtask

  task automatic test_out_of_range();
    mode = 2'b01; sel = 3'd5;
    cycle();
    sel = 3'd7;
    cycle();
    n_vec++; if (d_out !== 6'b100000) begin n_bad++; $display("FAIL oor_hold: got %b expected 100000", d_out); end
    n_vec++; if (err !== 1'b1) begin n_bad++; $display("FAIL oor_err: got %b expected 1", err); end
    mode = 2'b00; err_clr = 1'b1;
    cycle();
    n_vec++; if (err !== 1'b0) begin n_bad++; $display("FAIL err_clr: got %b expected 0", err); end
    mode = 2'b01; sel = 3'd6;
    cycle();
    n_vec++; if (err !== 1'b1) begin n_bad++; $display("FAIL set_beats_clr: got %b expected 1", err); end
    n_vec++; if (d_out !== 6'b100000) begin n_bad++; $display("FAIL oor6_hold: got %b expected 100000", d_out); end
    mode = 2'b00;
    cycle();
    err_clr = 1'b0;
    n_vec++; if (err !== 1'b0) begin n_bad++; $display("FAIL err_clr2: got %b expected 0", err); end
  endtask

  task automatic test_scan();
    logic [N_OUT-1:0] exp_d;
    logic             exp_w;
    int               wraps;
    mode = 2'b10; dwell = 4'd2;
    cycle();
    n_vec++; if (d_out !== 6'b000001) begin n_bad++; $display("FAIL scan_entry: got %b expected 000001", d_out); end
    n_vec++; if (scan_wrap !== 1'b0) begin n_bad++; $display("FAIL scan_entry_wrap: got %b expected 0", scan_wrap); end
    wraps = 0;
    for (int k = 1; k < 36; k++) begin
      cycle();
      exp_d = 6'b000001 << ((k / 3) % 6);
      exp_w = (k % 18 == 0);
      wraps += int'(scan_wrap);
      n_vec++; if (d_out !== exp_d) begin n_bad++; $display("FAIL scan_d2_k%0d: got %b expected %b", k, d_out, exp_d); end
      n_vec++; if (scan_wrap !== exp_w) begin n_bad++; $display("FAIL scan_wrap_d2_k%0d: got %b expected %b", k, scan_wrap, exp_w); end
    end
    n_vec++; if (wraps != 1) begin n_bad++; $display("FAIL scan_wrap_count_d2: got %0d expected 1", wraps); end
    dwell = 4'd0;
    for (int j = 0; j < 12; j++) begin
      cycle();
      exp_d = 6'b000001 << (j % 6);
      exp_w = (j % 6 == 0);
      n_vec++; if (d_out !== exp_d) begin n_bad++; $display("FAIL scan_d0_j%0d: got %b expected %b", j, d_out, exp_d); end
      n_vec++; if (scan_wrap !== exp_w) begin n_bad++; $display("FAIL scan_wrap_d0_j%0d: got %b expected %b", j, scan_wrap, exp_w); end
    end
  endtask

  task automatic test_freeze();
    mode = 2'b00;
    cycle();
    mode = 2'b10; dwell = 4'd3;
    cycle();
    cycle();
    cycle();
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      n_vec++; if (d_out !== 6'b000001) begin n_bad++; $display("FAIL freeze_i%0d: got %b expected 000001", i, d_out); end
    end
    en = 1'b1;
    cycle();
    n_vec++; if (d_out !== 6'b000001) begin n_bad++; $display("FAIL resume_last_dwell: got %b expected 000001", d_out); end
    cycle();
    n_vec++; if (d_out !== 6'b000010) begin n_bad++; $display("FAIL resume_advance: got %b expected 000010", d_out); end
  endtask

  task automatic test_reserved();
    mode = 2'b11;
    cycle();
    n_vec++; if (err !== 1'b1) begin n_bad++; $display("FAIL rsvd_err: got %b expected 1", err); end
    n_vec++; if (d_out !== 6'b000010) begin n_bad++; $display("FAIL rsvd_hold: got %b expected 000010", d_out); end
    mode = 2'b10;
    cycle();
    n_vec++; if (d_out !== 6'b000001) begin n_bad++; $display("FAIL rsvd_to_scan: got %b expected 000001", d_out); end
    n_vec++; if (scan_wrap !== 1'b0) begin n_bad++; $display("FAIL rsvd_to_scan_wrap: got %b expected 0", scan_wrap); end
    n_vec++; if (err !== 1'b1) begin n_bad++; $display("FAIL err_sticky: got %b expected 1", err); end
  endtask

  task automatic test_back_to_back();
    mode = 2'b01; sel = 3'd4;
    cycle();
    n_vec++; if (d_out !== 6'b010000) begin n_bad++; $display("FAIL scan_to_direct: got %b expected 010000", d_out); end
  endtask

  task automatic test_async_reset();
    mode = 2'b10; dwell = 4'd1;
    cycle();
    cycle();
    cycle();
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if (d_out !== 6'b000000) begin n_bad++; $display("FAIL async_d_out: got %b expected 000000", d_out); end
    n_vec++; if (valid !== 1'b0) begin n_bad++; $display("FAIL async_valid: got %b expected 0", valid); end
    n_vec++; if (err !== 1'b0) begin n_bad++; $display("FAIL async_err: got %b expected 0", err); end
    mode = 2'b01; sel = 3'd3;
    cycle();
    rst_n = 1'b1;
    cycle();
    n_vec++; if (d_out !== 6'b001000) begin n_bad++; $display("FAIL post_reset_direct: got %b expected 001000", d_out); end
    n_vec++; if (valid !== 1'b1) begin n_bad++; $display("FAIL post_reset_valid: got %b expected 1", valid); end
  endtask

  initial begin
    test_reset();
    test_direct();
    test_out_of_range();
    test_scan();
    test_freeze();
    test_reserved();
    test_back_to_back();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/decoder_scan.md
# decoder_scan

Parametrised registered one-hot decoder with an auto-scan mode. It turns a binary select into a one-hot output vector, either on demand (DIRECT) or by walking the active bit across all outputs with a programmable dwell (SCAN). It sits between control logic and banks of enables or chip-selects. Out-of-range selects and reserved modes raise a sticky error flag, which software clears with an explicit pulse.

## Interface
Parameters:
- SEL_W, 2, select width in bits.
- N_OUT, 2**SEL_W, number of one-hot outputs. Legal range is 2 ≤ N_OUT ≤ 2**SEL_W.
- DWELL_W, 8, width of the dwell count.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- en  in  1  clock-enable for all state. When 0, every register holds.
- mode  in  2  00 HOLD, 01 DIRECT, 10 SCAN, 11 reserved.
- sel  in  SEL_W  binary index used in DIRECT mode.
- dwell  in  DWELL_W  extra cycles each output stays active in SCAN.
- err_clr  in  1  clears err.
- d_out  out  N_OUT  registered one-hot (or all-zero) output.
- valid  out  1  d_out holds a decoded or scanned value.
- err  out  1  sticky error flag.
- scan_wrap  out  1  one-cycle pulse when SCAN wraps from the last output to output 0.

## Operation
- Reset values: d_out=0, valid=0, err=0, scan_wrap=0. Internal state: index=0, dwell_cnt=0, prev_mode=HOLD.
- mode is evaluated only on cycles with en=1. With en=0, d_out, valid, index, dwell_cnt and prev_mode freeze. err_clr and scan_wrap still act: err_clr clears err, and scan_wrap returns to 0.
- HOLD: d_out and valid keep their last values. index and dwell_cnt hold.
- DIRECT:
  - If sel < N_OUT: d_out ← 1<<sel, valid ← 1, index ← sel.
  - Otherwise: d_out and valid hold, and err ← 1.
- SCAN entry (prev_mode ≠ SCAN): d_out ← 1 (bit 0), index ← 0, dwell_cnt ← 0, valid ← 1.
- SCAN steady state:
  - If dwell_cnt ≥ dwell: index advances (N_OUT-1 wraps to 0), d_out ← 1<<index_next, dwell_cnt ← 0.
  - Otherwise: dwell_cnt increments.
  - dwell=0 advances every enabled cycle.
  - The comparison uses the live dwell value. Lowering dwell mid-scan advances on the next enabled cycle.
- scan_wrap is 1 for exactly one cycle, the cycle d_out changes from bit N_OUT-1 to bit 0. It does not pulse on SCAN entry.
- Reserved mode (11): outputs hold and err ← 1.
- err is sticky. err_clr clears it. If an error is set and err_clr is asserted in the same cycle, the set wins and err stays 1.
- A mode change takes effect on the same edge it is sampled. SCAN→DIRECT decodes sel on that edge.

## Timing
- Every output is a flop. Latency from sel/mode/en to d_out is 1 clock.
- rst_n assertion clears all outputs immediately, with no clock required, including mid-scan.
- Deassertion is synchronised externally. The first enabled edge after release behaves as a normal cycle.
- d_out is never more than one-hot. There is no cycle with two bits set during mode changes.

## Structure
- Shared package decoder_pkg holds:
  - mode localparams MODE_HOLD, MODE_DIRECT, MODE_SCAN, MODE_RSVD
  - the mode typedef
- Sub-module onehot_dec is purely combinational. It is parametrised by SEL_W and N_OUT, takes an index, and returns a one-hot vector plus an in_range flag. It is shared by the DIRECT and SCAN paths.
- The top level holds the index/dwell counters, prev_mode, error logic and output registers.

## Test plan
All scenarios use SEL_W=3, N_OUT=6, DWELL_W=4.
- DIRECT decode: en=1, mode=01, sel=5 → next edge d_out=6'b100000, valid=1, err=0. Then sel=0 → d_out=6'b000001.
- Out-of-range select: mode=01, sel=7 → d_out holds 6'b100000 and err=1. err_clr alone → err=0 next edge. err_clr with sel=6 in the same cycle → err stays 1.
- SCAN with dwell=2:
  - Each bit is held 3 cycles: 000001, 000010, … 100000, then 000001.
  - scan_wrap=1 only on the 100000→000001 edge, and the full period is 18 cycles.
  - With dwell=0, the period is 6 cycles.
- Enable freeze: SCAN with dwell=3, en=0 for 5 cycles mid-dwell → d_out and dwell timing frozen. After en=1 the scan resumes from the remaining count.
- Reserved mode and entry: mode=11 → err=1 and d_out unchanged. Switching to SCAN → d_out=000001 with no scan_wrap pulse.
- Async reset: rst_n low between clock edges during SCAN → d_out=0, valid=0, err=0 before the next edge. After release with mode=01, sel=3 → d_out=6'b001000 one edge later.
